home_automation: RTL and testbench

//  Clocked home-energy controller. Picks the fridge cooling mode from the usage profile
//  and time of day. Powers the computer down after sustained inactivity when nobody is

---
 rtl/home_automation_pkg.sv | 17 +
 rtl/home_automation_presence_filter.sv | 37 +++
 rtl/home_automation.sv | 97 +++++++++
 tb/tb_home_automation.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/home_automation_pkg.sv
// Shared types and default constants for the home-energy controller.
package home_automation_pkg;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_ON        = 2'd1,
        ST_COUNTDOWN = 2'd2
    } comp_state_t;

    localparam int DEF_IDLE_LIMIT    = 4;
    localparam int DEF_PRESENCE_HOLD = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/home_automation_presence_filter.sv
// Occupancy debounce: presence is dropped only after PRESENCE_HOLD
// consecutive low samples; any high sample reasserts it at once.
module presence_filter
    import home_automation_pkg::*;
#(
    parameter int PRESENCE_HOLD = DEF_PRESENCE_HOLD,
    parameter int CNT_W         = $clog2(PRESENCE_HOLD + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic presence_detected,
    output logic present_q
);

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(PRESENCE_HOLD);

    logic [CNT_W-1:0] abs_cnt;
    logic [CNT_W-1:0] abs_inc;

    assign abs_inc = abs_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            present_q <= 1'b0;
            abs_cnt   <= '0;
        end else if (presence_detected) begin
            present_q <= 1'b1;
            abs_cnt   <= '0;
        end else if (abs_cnt != HOLD) begin
            abs_cnt <= abs_inc;
            if (abs_inc == HOLD) begin
                present_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/home_automation.sv
// Home-energy controller: fridge eco/normal mode and computer power
// management driven by inactivity, occupancy and time of day.
module home_automation
    import home_automation_pkg::*;
#(
    parameter int IDLE_LIMIT    = DEF_IDLE_LIMIT,
    parameter int PRESENCE_HOLD = DEF_PRESENCE_HOLD,
    parameter int CNT_W         =
        $clog2(max_int(IDLE_LIMIT, PRESENCE_HOLD) + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic usage_profile,
    input  logic time_of_day,
    input  logic computer_inactive,
    input  logic presence_detected,
    output logic fridge_control,
    output logic computer_control
);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LIMIT - 1);

    comp_state_t      state_q;
    comp_state_t      state_d;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_d;
    logic             present_q;
    logic             shutdown_ok;
    logic             idle_ok;

    presence_filter #(
        .PRESENCE_HOLD (PRESENCE_HOLD),
        .CNT_W         (CNT_W)
    ) u_presence (
        .clk               (clk),
        .rst               (rst),
        .presence_detected (presence_detected),
        .present_q         (present_q)
    );

    assign shutdown_ok = ~present_q | time_of_day;
    assign idle_ok     = computer_inactive & shutdown_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            fridge_control <= 1'b1;
        end else begin
            fridge_control <= usage_profile | ~time_of_day;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            idle_cnt <= '0;
        end else begin
            state_q  <= state_d;
            idle_cnt <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt;
        unique case (state_q)
            ST_OFF: begin
                if (presence_detected && !computer_inactive) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (idle_ok) begin
                    state_d    = ST_COUNTDOWN;
                    idle_cnt_d = CNT_W'(1);
                end
            end
            ST_COUNTDOWN: begin
                if (!idle_ok) begin
                    state_d    = ST_ON;
                    idle_cnt_d = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_d    = ST_OFF;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_d    = ST_OFF;
                idle_cnt_d = '0;
            end
        endcase
    end

    assign computer_control = (state_q != ST_OFF);

endmodule

// File: tb/tb_home_automation.sv
// Directed bench for home_automation with IDLE_LIMIT=4, PRESENCE_HOLD=2.
module tb_home_automation;
    import home_automation_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic usage_profile;
    logic time_of_day;
    logic computer_inactive;
    logic presence_detected;
    logic fridge_control;
    logic computer_control;

    int vectors = 0;
    int errors  = 0;

    home_automation #(
        .IDLE_LIMIT    (4),
        .PRESENCE_HOLD (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .usage_profile     (usage_profile),
        .time_of_day       (time_of_day),
        .computer_inactive (computer_inactive),
        .presence_detected (presence_detected),
        .fridge_control    (fridge_control),
        .computer_control  (computer_control)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic u, input logic t,
                         input logic i, input logic p);
        usage_profile     = u;
        time_of_day       = t;
        computer_inactive = i;
        presence_detected = p;
    endtask

    initial begin
        logic [3:0] combo;

        // 1. reset, held with inputs that would otherwise change outputs
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_fridge", {7'd0, fridge_control}, 8'd1);
            check("rst_comp", {7'd0, computer_control}, 8'd0);
        end
        rst = 1'b0;

        // 2. fridge truth table over all 16 input combinations
        for (int k = 0; k < 16; k++) begin
            combo = 4'(k);
            drive(combo[3], combo[2], combo[1], combo[0]);
            for (int c = 0; c < 10; c++) begin
                step();
                check("fridge_sweep", {7'd0, fridge_control},
                      {7'd0, combo[3] | ~combo[2]});
            end
        end

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        check("post_rst_comp", {7'd0, computer_control}, 8'd0);

        // presence together with inactivity keeps the computer off
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check("off_inactive_arrival", {7'd0, computer_control}, 8'd0);

        // 3. power up, then day-time absence shutdown after 2+4 edges
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("power_up", {7'd0, computer_control}, 8'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            step();
            check("absent_hold", {7'd0, computer_control}, 8'd1);
        end
        step();
        check("absent_off", {7'd0, computer_control}, 8'd0);

        // 4. night permits shutdown while present
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("night_on", {7'd0, computer_control}, 8'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            step();
            check("night_hold", {7'd0, computer_control}, 8'd1);
        end
        step();
        check("night_off", {7'd0, computer_control}, 8'd0);

        // 5. countdown abort restarts the count
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("abort_on", {7'd0, computer_control}, 8'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check("abort_idle2", 8'(dut.idle_cnt), 8'd2);
        check("abort_cd_state", 8'(dut.state_q), 8'(ST_COUNTDOWN));
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("abort_state", 8'(dut.state_q), 8'(ST_ON));
        check("abort_idle0", 8'(dut.idle_cnt), 8'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            step();
            check("abort_hold", {7'd0, computer_control}, 8'd1);
        end
        step();
        check("abort_off", {7'd0, computer_control}, 8'd0);

        // 6. reset in the middle of a countdown
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check("mid_idle_pre", 8'(dut.idle_cnt), 8'd2);
        check("mid_fridge_pre", {7'd0, fridge_control}, 8'd0);
        rst = 1'b1;
        step();
        check("mid_rst_comp", {7'd0, computer_control}, 8'd0);
        check("mid_rst_fridge", {7'd0, fridge_control}, 8'd1);
        check("mid_rst_idle", 8'(dut.idle_cnt), 8'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
